// File: rtl/prim_clock_gate_ctrl.sv
// Multi-channel automatic clock gate: idle detection, four-phase idle req/ack, latch-based glitch-free gating.
// Status outputs update one clk_i edge after the sampled condition; gated clocks follow one pulse later.

module prim_clock_gate_cell (
  input  logic clk,
  input  logic en,
  input  logic test_en,
  output logic gclk
);

  logic en_latch;

  // Transparent only while clk is low, so enable changes never cut a high phase short.
  always_latch begin
    if (!clk) begin
      en_latch <= en | test_en;
    end
  end

  assign gclk = en_latch & clk;

endmodule

module prim_clock_gate_fsm #(
  parameter int IdleCycles = 16,
  parameter int WakeCycles = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic auto_en,
  input  logic busy,
  input  logic idle_ack,
  output logic en,
  output logic idle_req,
  output logic ready,
  output logic gated
);

  localparam int ICW = $clog2(IdleCycles + 1);
  localparam int WCW = $clog2(WakeCycles + 1);

  localparam logic [ICW-1:0] IDLE_LAST = ICW'(IdleCycles - 1);
  localparam logic [ICW-1:0] IDLE_SAT  = ICW'(IdleCycles);
  localparam logic [WCW-1:0] WAKE_LAST = WCW'(WakeCycles - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_REQ    = 2'd1,
    ST_OFF    = 2'd2,
    ST_WAKE   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
  logic [WCW-1:0] wake_cnt_q, wake_cnt_d;
  logic           idle;

  assign idle = auto_en & ~busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACTIVE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  // Any sign of work (or loss of permission) outranks the domain's ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACTIVE: begin
        if (idle && idle_cnt_q == IDLE_LAST) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!idle) begin
          state_d = ST_ACTIVE;
        end else if (idle_ack) begin
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        if (!idle) begin
          state_d = ST_WAKE;
        end
      end
      ST_WAKE: begin
        if (!idle_ack && wake_cnt_q == WAKE_LAST) begin
          state_d = ST_ACTIVE;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  always_comb begin
    idle_cnt_d = '0;
    wake_cnt_d = '0;
    case (state_q)
      ST_ACTIVE: begin
        if (idle) begin
          idle_cnt_d = (idle_cnt_q == IDLE_SAT) ? idle_cnt_q : idle_cnt_q + 1'b1;
        end
      end
      ST_REQ: begin
        if (idle) begin
          idle_cnt_d = idle_cnt_q;
        end
      end
      ST_WAKE: begin
        // Settle time only accrues once the domain has dropped its ack.
        if (state_d == ST_WAKE) begin
          wake_cnt_d = idle_ack ? wake_cnt_q : wake_cnt_q + 1'b1;
        end
      end
      default: begin
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    en       = 1'b1;
    idle_req = 1'b0;
    ready    = 1'b1;
    gated    = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        en       = 1'b1;
        idle_req = 1'b0;
        ready    = 1'b1;
      end
      ST_REQ: begin
        en       = 1'b1;
        idle_req = 1'b1;
        ready    = 1'b1;
      end
      ST_OFF: begin
        en       = 1'b0;
        idle_req = 1'b1;
        ready    = 1'b0;
        gated    = 1'b1;
      end
      ST_WAKE: begin
        en       = 1'b1;
        idle_req = 1'b0;
        ready    = 1'b0;
      end
      default: begin
        en       = 1'b1;
        idle_req = 1'b0;
        ready    = 1'b1;
      end
    endcase
  end

endmodule

module prim_clock_gate_ctrl #(
  parameter int NumCh      = 4,
  parameter int IdleCycles = 16,
  parameter int WakeCycles = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NumCh-1:0] auto_en_i,
  input  logic [NumCh-1:0] busy_i,
  input  logic             test_en_i,
  output logic [NumCh-1:0] idle_req_o,
  input  logic [NumCh-1:0] idle_ack_i,
  output logic [NumCh-1:0] clk_o,
  output logic [NumCh-1:0] ready_o,
  output logic [NumCh-1:0] gated_o
);

  logic [NumCh-1:0] en;

  for (genvar ch = 0; ch < NumCh; ch++) begin : g_ch
    prim_clock_gate_fsm #(
      .IdleCycles(IdleCycles),
      .WakeCycles(WakeCycles)
    ) u_fsm (
      .clk      (clk_i),
      .rst      (rst_i),
      .auto_en  (auto_en_i[ch]),
      .busy     (busy_i[ch]),
      .idle_ack (idle_ack_i[ch]),
      .en       (en[ch]),
      .idle_req (idle_req_o[ch]),
      .ready    (ready_o[ch]),
      .gated    (gated_o[ch])
    );

    prim_clock_gate_cell u_cell (
      .clk     (clk_i),
      .en      (en[ch]),
      .test_en (test_en_i),
      .gclk    (clk_o[ch])
    );
  end

endmodule

// File: doc/prim_clock_gate_ctrl.md
Name: prim_clock_gate_ctrl

Overview:
- Multi-channel automatic clock-gating controller. Per channel: idle detection, a four-phase idle request/acknowledge handshake with the clocked domain, and a glitch-free latch-based gate cell.
- Sits between the top-level clock and each leaf domain (peripherals, accelerators).
- Successor to the single-channel gate: parametrised channel count, hysteresis, handshake and wake-up settle time.

Parameters:
- NumCh, 4, number of independently gated channels (>=1).
- IdleCycles, 16, consecutive idle cycles required before an idle request is raised (>=1).
- WakeCycles, 2, settle cycles after clock restart before ready_o reasserts (>=1).

Ports:
- clk_i  input  1  ungated source clock.
- rst_i  input  1  synchronous, active-high reset.
- auto_en_i  input  NumCh  per-channel permission for automatic gating.
- busy_i  input  NumCh  channel has work pending; level, synchronous to clk_i.
- test_en_i  input  1  scan/test override, forces all clocks on.
- idle_req_o  output  NumCh  request to the domain to quiesce for gating.
- idle_ack_i  input  NumCh  domain is quiescent and accepts gating.
- clk_o  output  NumCh  gated clocks.
- ready_o  output  NumCh  channel clock is stable and usable.
- gated_o  output  NumCh  channel clock is currently gated off (FSM in OFF).

Behaviour:
- Reset: rst_i is synchronous and active-high. All FSMs enter ACTIVE, counters are 0, idle_req_o=0, ready_o=1, gated_o=0, clocks are enabled.
  - Mid-operation reset, including from OFF, takes effect at the next clk_i edge. Gating enable returns to 1; the clock resumes from the following pulse.
- Per-channel FSM with states ACTIVE, REQ, OFF, WAKE. Channels are fully independent.
- ACTIVE: en=1, ready_o=1, idle_req_o=0.
  - Idle counter clears when busy_i=1 or auto_en_i=0, otherwise increments.
  - On the edge that samples the IdleCycles-th consecutive idle cycle (counter==IdleCycles-1, busy_i=0, auto_en_i=1), go to REQ.
  - Counter saturates; its width is clog2(IdleCycles+1).
- REQ: en=1, ready_o=1, idle_req_o=1.
  - busy_i=1 or auto_en_i=0: go to ACTIVE (abort), counter cleared. Abort has priority over idle_ack_i in the same cycle.
  - Else idle_ack_i=1: go to OFF.
- OFF: en=0, ready_o=0, idle_req_o=1, gated_o=1.
  - busy_i=1 or auto_en_i=0: go to WAKE.
- WAKE: en=1, ready_o=0, idle_req_o=0.
  - Wake counter counts from 0.
  - Go to ACTIVE when the counter has reached WakeCycles-1 and idle_ack_i=0. The counter holds its value while ack is still high.
- Gate cell, per channel:
  - gate_en = en | test_en_i, where en is decoded combinationally from the registered state.
  - A latch is transparent while clk_i is low; clk_o = latch_q & clk_i.
  - No glitches or truncated pulses on any enable change.
  - Entering OFF at edge k suppresses clock pulse k+1 onward. Leaving OFF at edge k restores pulse k+1.
- test_en_i=1: clk_o follows clk_i for all channels. FSM, counters and handshake outputs are unaffected.
- idle_ack_i is ignored in ACTIVE and OFF.
- The handshake is four-phase: the domain must drop idle_ack_i after idle_req_o falls, and WAKE waits for this.
- Outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs other than clk_i to clk_o.

Test Plan:
- Basic gating (NumCh=4, IdleCycles=4, WakeCycles=2):
  - Stimulus: release reset, ch0 auto_en=1, busy=0.
  - Required: idle_req_o[0] rises on the 4th edge after reset. After idle_ack_i[0]=1 is sampled, gated_o[0]=1 and clk_o[0] has no pulses from the next cycle. Channels 1-3 keep toggling.
- Abort:
  - Stimulus: in REQ, assert busy_i[0] for 1 cycle together with idle_ack_i[0]=1.
  - Required: returns to ACTIVE, idle_req_o=0, clock never stops. idle_req_o reasserts only after 4 new idle cycles.
- Wake:
  - Stimulus: in OFF, busy_i[0]=1.
  - Required: next edge idle_req_o=0, clk_o pulses resume the following cycle. Hold idle_ack_i high 3 more cycles, then low: ready_o rises 2 cycles after ack low (WakeCycles=2), not before.
- Test override:
  - Stimulus: in OFF, test_en_i=1 for 5 cycles.
  - Required: 5 full clk_o[0] pulses, gated_o[0] stays 1, state unchanged. Deassert test_en_i and the clock stops again, with no runt pulse.
- Reset mid-operation:
  - Stimulus: ch0 in OFF, ch1 in WAKE; assert rst_i 1 cycle.
  - Required: both in ACTIVE, ready_o=1, idle_req_o=0, clocks running from the pulse after the reset edge.
- auto_en disable:
  - Stimulus: auto_en_i[2]=0 with busy=0 for 100 cycles.
  - Required: no idle_req_o[2], clk_o[2] continuous. Clearing auto_en_i in OFF causes a wake.
